// File: rtl/clock_ratio_meter_pkg.sv
// rtl/clock_ratio_meter_pkg.sv - shared state type and synchronizer depth for clock_ratio_meter
package clock_ratio_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with a one-cycle rising-edge pulse
module sync_edge_detect
  import clock_ratio_meter_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// rtl/clock_ratio_meter.sv - averaged period measurement of an async input in clock_i cycles
// Optional jitter_o (max-min sample per window) when CLOCK_RATIO_METER_JITTER_EN is defined.
module clock_ratio_meter
  import clock_ratio_meter_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 sig_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 locked_o,
  output logic                 overflow_o,
`ifdef CLOCK_RATIO_METER_JITTER_EN
  output logic [CNT_WIDTH-1:0] jitter_o,
`endif
  output logic                 dropped_o
);

  localparam int ACC_W  = CNT_WIDTH + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic [NPER_W-1:0]    WINDOW  = NPER_W'(2 ** AVG_LOG2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]     accum_q, accum_d;
  logic [NPER_W-1:0]    nper_q, nper_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 overflow_q, overflow_d;
  logic                 dropped_q, dropped_d;

  logic                 rise;
  logic                 new_result;
  logic [CNT_WIDTH-1:0] sample;
  logic [ACC_W-1:0]     accum_sum;
  logic [NPER_W-1:0]    nper_inc;
  logic [CNT_WIDTH-1:0] result;

  sync_edge_detect u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .async_i (sig_i),
    .rise_o  (rise)
  );

  // An edge landing on a full counter saturates the sample, so the accumulator cannot wrap.
  assign sample    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_WIDTH'(1);
  assign accum_sum = accum_q + ACC_W'(sample);
  assign nper_inc  = nper_q + NPER_W'(1);
  assign result    = CNT_WIDTH'(accum_sum >> AVG_LOG2);

`ifdef CLOCK_RATIO_METER_JITTER_EN
  logic [CNT_WIDTH-1:0] min_q, min_d, max_q, max_d, jitter_q, jitter_d;
  logic [CNT_WIDTH-1:0] smin, smax;
  assign smin = (sample < min_q) ? sample : min_q;
  assign smax = (sample > max_q) ? sample : max_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accum_d    = accum_q;
    nper_d     = nper_q;
    period_d   = period_q;
    valid_d    = valid_q & ~ready_i;
    locked_d   = locked_q;
    overflow_d = 1'b0;
    dropped_d  = 1'b0;
    new_result = 1'b0;
`ifdef CLOCK_RATIO_METER_JITTER_EN
    min_d      = min_q;
    max_d      = max_q;
    jitter_d   = jitter_q;
`endif
    if (!en_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      accum_d  = '0;
      nper_d   = '0;
      valid_d  = 1'b0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = '0;
            accum_d = '0;
            nper_d  = '0;
`ifdef CLOCK_RATIO_METER_JITTER_EN
            min_d   = CNT_MAX;
            max_d   = '0;
`endif
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt_d = '0;
            if (nper_inc == WINDOW) begin
              new_result = 1'b1;
              accum_d    = '0;
              nper_d     = '0;
`ifdef CLOCK_RATIO_METER_JITTER_EN
              jitter_d   = valid_q && !ready_i ? jitter_q : smax - smin;
              min_d      = CNT_MAX;
              max_d      = '0;
`endif
            end else begin
              accum_d = accum_sum;
              nper_d  = nper_inc;
`ifdef CLOCK_RATIO_METER_JITTER_EN
              min_d   = smin;
              max_d   = smax;
`endif
            end
          end else if (cnt_q == CNT_MAX) begin
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            accum_d    = '0;
            nper_d     = '0;
            cnt_d      = '0;
            state_d    = ARM;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A result finishing while the previous one is still unaccepted is discarded.
    if (new_result) begin
      if (valid_q && !ready_i) begin
        dropped_d = 1'b1;
      end else begin
        period_d = result;
        valid_d  = 1'b1;
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      accum_q    <= '0;
      nper_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
`ifdef CLOCK_RATIO_METER_JITTER_EN
      min_q      <= CNT_MAX;
      max_q      <= '0;
      jitter_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      accum_q    <= accum_d;
      nper_q     <= nper_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
`ifdef CLOCK_RATIO_METER_JITTER_EN
      min_q      <= min_d;
      max_q      <= max_d;
      jitter_q   <= jitter_d;
`endif
    end
  end

  assign period_o   = period_q;
  assign valid_o    = valid_q;
  assign locked_o   = locked_q;
  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;
`ifdef CLOCK_RATIO_METER_JITTER_EN
  assign jitter_o   = jitter_q;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// tb/tb_clock_ratio_meter.sv - directed self-checking bench for clock_ratio_meter (CNT_WIDTH=8, AVG_LOG2=2)
module tb_clock_ratio_meter;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       en_i;
  logic       sig_i;
  logic [7:0] period_o;
  logic       valid_o;
  logic       ready_i;
  logic       locked_o;
  logic       overflow_o;
  logic       dropped_o;
`ifdef CLOCK_RATIO_METER_JITTER_EN
  logic [7:0] jitter_o;
`endif

  clock_ratio_meter #(.CNT_WIDTH(8), .AVG_LOG2(2)) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .sig_i      (sig_i),
    .period_o   (period_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .locked_o   (locked_o),
    .overflow_o (overflow_o),
`ifdef CLOCK_RATIO_METER_JITTER_EN
    .jitter_o   (jitter_o),
`endif
    .dropped_o  (dropped_o)
  );

  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // sig_i generator: changes 1 ns after each rising edge of clock_i
  bit gen_on = 1'b0;
  bit alt    = 1'b0;
  bit tog    = 1'b0;
  int base_p = 16;
  int cur_p  = 16;
  int ph     = 0;
  int cyc    = 0;
  int rises  = 0;
  int last_rise = 0;

  initial begin
    sig_i = 1'b0;
    forever begin
      @(posedge clock_i);
      #1;
      cyc++;
      if (!gen_on) begin
        sig_i = 1'b0;
        ph    = 0;
      end else begin
        if (ph == 0) begin
          if (alt) begin
            tog   = !tog;
            cur_p = tog ? 14 : 18;
          end else begin
            cur_p = base_p;
          end
          rises++;
          last_rise = cyc;
        end
        sig_i = (ph < cur_p / 2);
        ph++;
        if (ph == cur_p) ph = 0;
      end
    end
  end

  task automatic wait_valid(input int max_cyc, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cyc) begin
      @(negedge clock_i);
      n++;
      if (valid_o) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int seen, base, t0, drops, vlow, changed, n;
    reset_i = 1'b1;
    en_i    = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check_eq("rst_period", int'(period_o), 0);
    check_eq("rst_valid", int'(valid_o), 0);
    check_eq("rst_locked", int'(locked_o), 0);
    check_eq("rst_overflow", int'(overflow_o), 0);
    check_eq("rst_dropped", int'(dropped_o), 0);

    // Disabled: toggling input must produce nothing
    reset_i = 1'b0;
    gen_on  = 1'b1;
    seen    = 0;
    repeat (200) begin
      @(negedge clock_i);
      seen += int'(valid_o) + int'(locked_o) + int'(overflow_o);
    end
    check_eq("en_low_quiet", seen, 0);

    // Arm with a clean first edge: 1 arm edge + 4 periods of 16
    gen_on = 1'b0;
    repeat (20) @(negedge clock_i);
    en_i = 1'b1;
    repeat (5) @(negedge clock_i);
    base   = rises;
    gen_on = 1'b1;
    wait_valid(200, ok);
    check_eq("first_valid_seen", int'(ok), 1);
    check_eq("first_valid_edges", rises - base, 5);
    check_eq("first_period", int'(period_o), 16);
    check_eq("first_locked", int'(locked_o), 1);
    t0 = cyc;
    @(negedge clock_i);
    check_eq("valid_one_cycle", int'(valid_o), 0);
    wait_valid(200, ok);
    check_eq("second_valid_seen", int'(ok), 1);
    check_eq("window_gap", cyc - t0, 64);
    check_eq("second_period", int'(period_o), 16);

    // Alternating 14/18: any four consecutive periods average 16
    alt = 1'b1;
    repeat (3) wait_valid(200, ok);
    check_eq("alt_valid_seen", int'(ok), 1);
    check_eq("alt_period", int'(period_o), 16);
`ifdef CLOCK_RATIO_METER_JITTER_EN
    check_eq("alt_jitter", int'(jitter_o), 4);
`endif
    alt = 1'b0;
    repeat (2) wait_valid(200, ok);

    // Stall: 2 sync + 1 detect + 255 counts + 1 register after the last rise
    gen_on = 1'b0;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 400) begin
      @(negedge clock_i);
      n++;
      if (overflow_o) ok = 1'b1;
    end
    check_eq("overflow_seen", int'(ok), 1);
    check_eq("overflow_latency", cyc - last_rise, 259);
    check_eq("overflow_unlocked", int'(locked_o), 0);
    @(negedge clock_i);
    check_eq("overflow_pulse", int'(overflow_o), 0);
    base   = rises;
    gen_on = 1'b1;
    wait_valid(300, ok);
    check_eq("rearm_valid_seen", int'(ok), 1);
    check_eq("rearm_edges", rises - base, 5);
    check_eq("rearm_period", int'(period_o), 16);

    // Backpressure across two windows; the second result (19) is dropped
    @(negedge clock_i);
    ready_i = 1'b0;
    wait_valid(200, ok);
    check_eq("held_valid_seen", int'(ok), 1);
    check_eq("held_period", int'(period_o), 16);
    base_p  = 20;
    drops   = 0;
    vlow    = 0;
    changed = 0;
    repeat (100) begin
      @(negedge clock_i);
      drops += int'(dropped_o);
      if (!valid_o) vlow++;
      if (period_o != 8'd16) changed++;
    end
    check_eq("dropped_count", drops, 1);
    check_eq("held_valid_low", vlow, 0);
    check_eq("held_period_changed", changed, 0);
    ready_i = 1'b1;
    @(negedge clock_i);
    check_eq("accept_valid_drop", int'(valid_o), 0);
    wait_valid(200, ok);
    check_eq("p20_valid_seen", int'(ok), 1);
    check_eq("p20_period", int'(period_o), 20);

    // Reset pulse mid-window, taken while sig_i is low
    repeat (10) @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    check_eq("midrst_valid", int'(valid_o), 0);
    check_eq("midrst_locked", int'(locked_o), 0);
    check_eq("midrst_period", int'(period_o), 0);
    check_eq("midrst_overflow", int'(overflow_o), 0);
    base = rises;
    wait_valid(300, ok);
    check_eq("postrst_valid_seen", int'(ok), 1);
    check_eq("postrst_edges", rises - base, 5);
    check_eq("postrst_period", int'(period_o), 20);
    check_eq("postrst_locked", int'(locked_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
